// File: rtl/alu_seq_flags.sv
// Registered, handshaked LEGv8 ALU with shifts and a persistent NZCV flags register.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 4'b1000).
module alu_seq_flags #(
   parameter int unsigned WIDTH       = 64,
   parameter logic [3:0]  FLAGS_RESET = 4'b0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic             flags_we,
   output logic [3:0]       nzcv
);

   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpOrr  = 4'b0001;
   localparam logic [3:0] OpAdd  = 4'b0010;
   localparam logic [3:0] OpLsl  = 4'b0011;
   localparam logic [3:0] OpLsr  = 4'b0100;
   localparam logic [3:0] OpSub  = 4'b0110;
   localparam logic [3:0] OpPassB = 4'b0111;
   localparam logic [3:0] OpPassA = 4'b1001;
   localparam logic [3:0] OpAdds = 4'b1010;
   localparam logic [3:0] OpNor  = 4'b1100;
   localparam logic [3:0] OpSubs = 4'b1110;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OpMul  = 4'b1000;
`endif

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;
   logic             flags_we_q, flags_we_d;
   logic [3:0]       nzcv_q, nzcv_d;

   logic             out_free;
   logic             accept;
   logic             mul_done;
   logic [WIDTH-1:0] mul_res;

   assign out_free = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // ---------------------------------------------------------------------------------------------
   // Single-cycle datapath
   // ---------------------------------------------------------------------------------------------
   logic             is_sub;
   logic [WIDTH:0]   sum;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_illegal;
   logic             alu_flag_op;
   logic             alu_mul;
   logic [3:0]       alu_nzcv;

   assign is_sub = (alu_control == OpSub) || (alu_control == OpSubs);
   assign shamt  = b[SHAMT_W-1:0];
   // Subtraction as a + ~b + 1 so the carry-out is the "no borrow" flag.
   assign sum    = {1'b0, a} + {1'b0, (is_sub ? ~b : b)} + {{WIDTH{1'b0}}, is_sub};

   always_comb begin
      alu_res     = '0;
      alu_illegal = 1'b0;
      alu_flag_op = 1'b0;
      alu_mul     = 1'b0;
      case (alu_control)
         OpAnd:   alu_res = a & b;
         OpOrr:   alu_res = a | b;
         OpNor:   alu_res = ~(a | b);
         OpPassA: alu_res = a;
         OpPassB: alu_res = b;
         OpAdd, OpSub: alu_res = sum[WIDTH-1:0];
         OpAdds, OpSubs: begin
            alu_res     = sum[WIDTH-1:0];
            alu_flag_op = 1'b1;
         end
         OpLsl:   alu_res = a << shamt;
         OpLsr:   alu_res = a >> shamt;
`ifdef ALU_MUL_EN
         OpMul:   alu_mul = 1'b1;
`endif
         default: alu_illegal = 1'b1;
      endcase
   end

   always_comb begin
      alu_nzcv[3] = sum[WIDTH-1];
      alu_nzcv[2] = (sum[WIDTH-1:0] == '0);
      alu_nzcv[1] = sum[WIDTH];
      if (is_sub) begin
         alu_nzcv[0] = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end else begin
         alu_nzcv[0] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
   end

`ifdef ALU_MUL_EN
   // ---------------------------------------------------------------------------------------------
   // Iterative multiplier: bit 0 is consumed at the accept edge, bits 1..WIDTH-1 in StMul
   // ---------------------------------------------------------------------------------------------
   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mul_acc_q, mul_acc_d;
   logic [WIDTH-1:0]   mul_a_q, mul_a_d;
   logic [WIDTH-1:0]   mul_b_q, mul_b_d;
   logic [SHAMT_W-1:0] step_q, step_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept && alu_mul) state_d = StMul;
         StMul:   if (mul_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready = (state_q == StIdle) && out_free;
      mul_done = (state_q == StMul) && (step_q == SHAMT_W'(WIDTH - 1));
   end

   assign mul_res = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);

   always_comb begin
      mul_acc_d = mul_acc_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      step_d    = step_q;
      if (accept && alu_mul) begin
         mul_acc_d = b[0] ? a : '0;
         mul_a_d   = a << 1;
         mul_b_d   = b >> 1;
         step_d    = SHAMT_W'(1);
      end else if (state_q == StMul) begin
         mul_acc_d = mul_res;
         mul_a_d   = mul_a_q << 1;
         mul_b_d   = mul_b_q >> 1;
         step_d    = step_q + SHAMT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_acc_q <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         step_q    <= '0;
      end else begin
         mul_acc_q <= mul_acc_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         step_q    <= step_d;
      end
   end
`else
   assign in_ready = out_free;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
`endif

   // ---------------------------------------------------------------------------------------------
   // Output beat and flags register
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      flags_we_d  = flags_we_q;
      nzcv_d      = nzcv_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept && !alu_mul) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         zero_d      = (alu_res == '0);
         illegal_d   = alu_illegal;
         flags_we_d  = alu_flag_op;
         if (alu_flag_op) begin
            nzcv_d = alu_nzcv;
         end
      end else if (mul_done) begin
         out_valid_d = 1'b1;
         result_d    = mul_res;
         zero_d      = (mul_res == '0);
         illegal_d   = 1'b0;
         flags_we_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         flags_we_q  <= 1'b0;
         nzcv_q      <= FLAGS_RESET;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         flags_we_q  <= flags_we_d;
         nzcv_q      <= nzcv_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign flags_we  = flags_we_q;
   assign nzcv      = nzcv_q;

endmodule

// File: tb/tb_alu_seq_flags.sv
// Scoreboard bench for alu_seq_flags: expected beats are queued at accept and
// compared when the DUT retires them. Honours ALU_MUL_EN like the design.
module tb_alu_seq_flags;

   localparam int unsigned W  = 64;
   localparam logic [3:0]  FR = 4'b0000;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [3:0]    alu_control;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          zero;
   logic          illegal;
   logic          flags_we;
   logic [3:0]    nzcv;

   alu_seq_flags #(
      .WIDTH       (W),
      .FLAGS_RESET (FR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .illegal     (illegal),
      .flags_we    (flags_we),
      .nzcv        (nzcv)
   );

   typedef struct {
      logic [63:0] r;
      logic        z;
      logic        ill;
      logic        fwe;
      logic [3:0]  nzcv;
      int          cyc;
      int          lat;   // 0 = latency not checked
   } exp_t;

   exp_t        sbq[$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   logic [3:0]  model_nzcv;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [63:0] x,
                                  input logic [63:0] y, input logic [3:0] nz);
      exp_t        e;
      logic [64:0] s;
      e.r = '0; e.ill = 1'b0; e.fwe = 1'b0; e.nzcv = nz; e.cyc = 0; e.lat = 1;
      case (op)
         4'b0000: e.r = x & y;
         4'b0001: e.r = x | y;
         4'b0010: e.r = x + y;
         4'b0110: e.r = x - y;
         4'b0111: e.r = y;
         4'b1001: e.r = x;
         4'b1100: e.r = ~(x | y);
         4'b0011: e.r = x << y[5:0];
         4'b0100: e.r = x >> y[5:0];
         4'b1010: begin
            s      = {1'b0, x} + {1'b0, y};
            e.r    = s[63:0];
            e.fwe  = 1'b1;
            e.nzcv = {e.r[63], (e.r == 64'd0), s[64], (x[63] == y[63]) && (e.r[63] != x[63])};
         end
         4'b1110: begin
            e.r    = x - y;
            e.fwe  = 1'b1;
            e.nzcv = {e.r[63], (e.r == 64'd0), (x >= y), (x[63] != y[63]) && (e.r[63] != x[63])};
         end
`ifdef ALU_MUL_EN
         4'b1000: begin
            e.r   = x * y;
            e.lat = W;
         end
`endif
         default: e.ill = 1'b1;
      endcase
      e.z = (e.r == 64'd0);
      return e;
   endfunction

   // Monitor: compare each retiring beat against the oldest expectation.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         check_val("beat_expected", 64'(sbq.size() > 0), 64'd1);
         if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check_val("result", result, e.r);
            check_val("zero", 64'(zero), 64'(e.z));
            check_val("illegal", 64'(illegal), 64'(e.ill));
            check_val("flags_we", 64'(flags_we), 64'(e.fwe));
            check_val("nzcv", 64'(nzcv), 64'(e.nzcv));
            if (e.lat != 0) check_val("latency", 64'(cyc - e.cyc), 64'(e.lat));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                       input bit chk_lat);
      exp_t e;
      bit   done;
      done        = 1'b0;
      alu_control = op;
      a           = x;
      b           = y;
      in_valid    = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e          = model(op, x, y, model_nzcv);
            model_nzcv = e.nzcv;
            e.cyc      = cyc;
            if (!chk_lat) e.lat = 0;
            sbq.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check_val("accept", 64'(done), 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sbq.size() > 0; i++) begin
         @(posedge clk);
         #1;
      end
      check_val("drain", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_hi;
      reset       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      a           = '0;
      b           = '0;
      alu_control = 4'b0000;
      model_nzcv  = FR;

      repeat (2) @(negedge clk);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_result", result, 64'd0);
      check_val("rst_zero", 64'(zero), 64'd0);
      check_val("rst_illegal", 64'(illegal), 64'd0);
      check_val("rst_flags_we", 64'(flags_we), 64'd0);
      check_val("rst_nzcv", 64'(nzcv), 64'(FR));
      check_val("rst_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Signed overflow on ADDS
      send(4'b1010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      drain();

      // SUBS equal, SUBS borrow, then a non-flag op leaves NZCV alone
      send(4'b1110, 64'd5, 64'd5, 1'b1);
      send(4'b1110, 64'd3, 64'd5, 1'b1);
      send(4'b0000, 64'hF0F0, 64'h0FF0, 1'b1);
      drain();

      // Back-to-back throughput
      send(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
      send(4'b0001, 64'hA000, 64'h000B, 1'b1);
      send(4'b0110, 64'd10, 64'd20, 1'b1);
      send(4'b1100, 64'h0F, 64'hF0, 1'b1);
      send(4'b0111, 64'h1234, 64'h5678, 1'b1);
      send(4'b1001, 64'h1234, 64'h5678, 1'b1);
      drain();

      // Output backpressure: beat holds and upstream stalls
      send(4'b0010, 64'd100, 64'd23, 1'b0);
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_val("stall_valid", 64'(out_valid), 64'd1);
         check_val("stall_result", result, 64'd123);
         check_val("stall_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Shift amounts use only the low bits of b
      send(4'b0011, 64'd1, 64'd70, 1'b1);
      send(4'b0100, 64'h8000_0000_0000_0000, 64'd63, 1'b1);
      drain();

      // Unsupported opcodes
      send(4'b0101, 64'h55, 64'h66, 1'b1);
`ifndef ALU_MUL_EN
      send(4'b1000, 64'd12345, 64'd678, 1'b1);
`endif
      drain();

`ifdef ALU_MUL_EN
      send(4'b1000, 64'd12345, 64'd678, 1'b1);
      busy_hi = 0;
      for (int i = 0; i < 200 && sbq.size() > 0; i++) begin
         @(negedge clk);
         if (!out_valid && in_ready) busy_hi++;
         @(posedge clk);
         #1;
      end
      check_val("mul_busy_in_ready", 64'(busy_hi), 64'd0);
      drain();
      send(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1);
      drain();

      // Abort a multiply with reset
      send(4'b1000, 64'd12345, 64'd678, 1'b1);
      repeat (9) @(posedge clk);
`else
      // Abort a pending beat with reset
      busy_hi = 0;
      out_ready = 1'b0;
      send(4'b0010, 64'd1, 64'd1, 1'b0);
      repeat (2) @(posedge clk);
`endif
      check_val("pre_rst_nzcv", 64'(nzcv), 64'(model_nzcv));
      #2;
      reset = 1'b0;
      #1;
      check_val("abort_out_valid", 64'(out_valid), 64'd0);
      check_val("abort_nzcv", 64'(nzcv), 64'(FR));
      sbq.delete();
      model_nzcv = FR;
      out_ready  = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
      repeat (70) @(posedge clk);
      #1;
      check_val("post_rst_no_beat", 64'(out_valid), 64'd0);

      send(4'b1110, 64'd5, 64'd5, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
